// File: rtl/core_dmem_pkg.sv
// Shared definitions for the core data-memory responder.
// State encoding, legal lane masks and small lane-mask helpers.
package core_dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10
    } state_e;

    localparam int CNT_W = 4;

    localparam logic [3:0] STRB_B0 = 4'b0001;
    localparam logic [3:0] STRB_B1 = 4'b0010;
    localparam logic [3:0] STRB_B2 = 4'b0100;
    localparam logic [3:0] STRB_B3 = 4'b1000;
    localparam logic [3:0] STRB_H0 = 4'b0011;
    localparam logic [3:0] STRB_H1 = 4'b0110;
    localparam logic [3:0] STRB_H2 = 4'b1100;
    localparam logic [3:0] STRB_W  = 4'b1111;

    typedef struct packed {
        logic        is_load;
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        sign_b;
        logic        sign_h;
        logic        err;
    } dmem_req_t;

    function automatic logic strb_is_byte(input logic [3:0] s);
        return (s == STRB_B0) || (s == STRB_B1) ||
               (s == STRB_B2) || (s == STRB_B3);
    endfunction

    function automatic logic strb_is_half(input logic [3:0] s);
        return (s == STRB_H0) || (s == STRB_H1) || (s == STRB_H2);
    endfunction

    function automatic logic strb_is_word(input logic [3:0] s);
        return s == STRB_W;
    endfunction

    // Index of the lowest enabled lane; where the load data starts.
    function automatic logic [1:0] strb_base(input logic [3:0] s);
        logic [1:0] b;
        b = 2'd0;
        if (s[0]) begin
            b = 2'd0;
        end else if (s[1]) begin
            b = 2'd1;
        end else if (s[2]) begin
            b = 2'd2;
        end else if (s[3]) begin
            b = 2'd3;
        end
        return b;
    endfunction

endpackage

// File: rtl/core_dmem_lane_extract.sv
// Load alignment: picks the lanes named by strb out of the raw
// RAM word, right-aligns them and applies sign or zero extension.
module core_dmem_lane_extract
    import core_dmem_pkg::*;
(
    input  logic [3:0]  strb,
    input  logic        sign_b,
    input  logic        sign_h,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    logic        is_b;
    logic        is_h;
    logic [31:0] aligned;

    assign is_b    = strb_is_byte(strb);
    assign is_h    = strb_is_half(strb);
    assign aligned = raw >> {strb_base(strb), 3'b000};

    always_comb begin
        result = raw;
        unique case (1'b1)
            is_b: result = {{24{sign_b & aligned[7]}}, aligned[7:0]};
            is_h: result = {{16{sign_h & aligned[15]}}, aligned[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/core_dmem_responder.sv
// Data-memory responder: latches a core load/store pulse, stalls for
// WAIT_STATES cycles, then performs the access on an internal RAM.
module core_dmem_responder
    import core_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        C_ISLOAD_SS,
    input  logic        C_ISSTORE_SS,
    input  logic [31:0] DMEM_ADDR,
    input  logic [31:0] DMEM_WDATA,
    input  logic [3:0]  STRB,
    input  logic        ISLOADBS,
    input  logic        ISLOADHWS,
    output logic [31:0] DMEM_RDATA,
    output logic        HCU_MEM_BUSY,
    output logic        DMEM_DONE,
    output logic        DMEM_ERR
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);
    localparam logic [29:0] DEPTH = 30'(DEPTH_WORDS);

    state_e           state;
    state_e           state_nx;
    logic [CNT_W-1:0] cnt;
    dmem_req_t        req;

    logic             start;
    logic             req_bad;
    logic             in_byte;
    logic             in_half;
    logic             in_word;

    logic             busy_nx;
    logic             done_nx;
    logic             err_nx;

    logic [AW-1:0]    widx;
    logic [31:0]      wdata_sh;
    logic [31:0]      raw;
    logic [31:0]      ext;
    logic             wr_en;
    logic             unused_addr;

    logic [31:0]      ram [DEPTH_WORDS];

    assign start = (state == ST_IDLE) & (C_ISLOAD_SS | C_ISSTORE_SS);

    assign in_byte = strb_is_byte(STRB);
    assign in_half = strb_is_half(STRB);
    assign in_word = strb_is_word(STRB);

    // Legality is judged on the live inputs and carried with the request.
    assign req_bad = (C_ISLOAD_SS & C_ISSTORE_SS)
                   | ~(in_byte | in_half | in_word)
                   | (in_half & DMEM_ADDR[0])
                   | (in_word & (|DMEM_ADDR[1:0]))
                   | (DMEM_ADDR[31:2] >= DEPTH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (WS == '0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the error flag is not latched yet.
    always_comb begin
        busy_nx = (state_nx != ST_IDLE);
        done_nx = (state_nx == ST_ACCESS);
        err_nx  = done_nx & ((state == ST_IDLE) ? req_bad : req.err);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            HCU_MEM_BUSY <= 1'b0;
            DMEM_DONE    <= 1'b0;
            DMEM_ERR     <= 1'b0;
        end else begin
            HCU_MEM_BUSY <= busy_nx;
            DMEM_DONE    <= done_nx;
            DMEM_ERR     <= err_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
            req <= '0;
        end else if (start) begin
            cnt <= WS;
            req <= '{
                is_load:  C_ISLOAD_SS,
                is_store: C_ISSTORE_SS,
                addr:     DMEM_ADDR,
                wdata:    DMEM_WDATA,
                strb:     STRB,
                sign_b:   ISLOADBS,
                sign_h:   ISLOADHWS,
                err:      req_bad
            };
        end else if (state == ST_WAIT) begin
            cnt <= cnt - CNT_W'(1);
        end else if (state == ST_ACCESS) begin
            cnt <= '0;
        end
    end

    assign widx        = req.addr[AW+1:2];
    assign wdata_sh    = req.wdata << {req.addr[1:0], 3'b000};
    assign raw         = ram[widx];
    assign unused_addr = ^req.addr[31:AW+2];

    assign wr_en = (state == ST_ACCESS) & req.is_store
                 & ~req.is_load & ~req.err & ~RST;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (req.strb[i]) begin
                    ram[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    core_dmem_lane_extract u_extract (
        .strb   (req.strb),
        .sign_b (req.sign_b),
        .sign_h (req.sign_h),
        .raw    (raw),
        .result (ext)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            DMEM_RDATA <= '0;
        end else if ((state == ST_ACCESS) && req.is_load) begin
            DMEM_RDATA <= req.err ? '0 : ext;
        end
    end

endmodule

// File: doc/core_dmem_responder.md
# core_dmem_responder

Data-memory responder for the pipelined RV32I core. Accepts the single-cycle load/store request pulses issued by the core's memory stage, stalls the pipeline through `HCU_MEM_BUSY` for a programmable number of wait states, and then performs the access on an internal word-organised RAM. Stores are lane-shifted and byte-masked. Loads are extracted, right-aligned and sign- or zero-extended before they are returned on `DMEM_RDATA`.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024 — RAM depth in 32-bit words; must be a power of two.
- `WAIT_STATES`, default 2 — extra busy cycles before the access cycle; legal range 0..15.

Ports:
- `CLK`  in  1  — single clock; everything is rising-edge.
- `RST`  in  1  — synchronous, active-high reset.
- `C_ISLOAD_SS`  in  1  — one-cycle load request pulse.
- `C_ISSTORE_SS`  in  1  — one-cycle store request pulse.
- `DMEM_ADDR`  in  32  — byte address.
- `DMEM_WDATA`  in  32  — store data, right-aligned (byte in [7:0], half in [15:0]).
- `STRB`  in  4  — lane mask, already shifted by `DMEM_ADDR[1:0]`: 0001<<n byte, 0011<<n half, 1111 word. Also defines load width.
- `ISLOADBS`  in  1  — signed byte load.
- `ISLOADHWS`  in  1  — signed halfword load.
- `DMEM_RDATA`  out  32  — extended load result; holds its value until the next load completes.
- `HCU_MEM_BUSY`  out  1  — high while a request is in flight.
- `DMEM_DONE`  out  1  — one-cycle pulse on access completion.
- `DMEM_ERR`  out  1  — one-cycle pulse coincident with `DMEM_DONE` on an illegal request.

## Operation
- FSM states: `IDLE`, `WAIT`, `ACCESS`.
- **IDLE:** on `C_ISLOAD_SS` or `C_ISSTORE_SS`, latch address, wdata, `STRB`, the sign flags and the op type. Load the wait counter with `WAIT_STATES`. Go to `WAIT`, or to `ACCESS` if `WAIT_STATES` = 0.
- **WAIT:** decrement the counter each cycle. At counter = 1, go to `ACCESS`.
- **ACCESS:** perform the access, pulse `DMEM_DONE`, return to `IDLE`.
- `HCU_MEM_BUSY` = (state != `IDLE`), registered.
- **Store:** `wdata << (8*addr[1:0])`. Write only the lanes whose `STRB` bit is set.
- **Load:**
  - Extract the lanes selected by `STRB` and right-align them.
  - Byte: sign-extend from bit 7 if `ISLOADBS`, otherwise zero-extend.
  - Half: sign-extend from bit 15 if `ISLOADHWS`, otherwise zero-extend.
  - Word: unchanged.
- **Illegal requests**, detected at latch time and reported in `ACCESS`: the store is dropped, a load returns `DMEM_RDATA` = 0, and `DMEM_ERR` pulses. A request is illegal if any of these holds:
  - both request pulses are high;
  - the `STRB` pattern is not one of the legal forms;
  - a half access has `addr[0]` = 1;
  - a word access has `addr[1:0]` != 0;
  - the word index `addr[31:2]` >= `DEPTH_WORDS`.
- Requests arriving while not in `IDLE` are ignored: no latch, no effect.
- `RST` mid-operation: the FSM returns to `IDLE` and any pending store is dropped. RAM contents are preserved.

## Timing
- Request sampled at edge T.
- `HCU_MEM_BUSY` is high in cycles T+1 .. T+`WAIT_STATES`+1, i.e. `WAIT_STATES`+1 cycles.
- `DMEM_DONE` and `DMEM_ERR` are high in cycle T+`WAIT_STATES`+1, the `ACCESS` cycle.
- The RAM write and the `DMEM_RDATA` update occur at the edge ending `ACCESS`. `DMEM_RDATA` is valid from T+`WAIT_STATES`+2, the first cycle with BUSY low.
- A new request is accepted in the first cycle with BUSY low, giving back-to-back throughput of one access per `WAIT_STATES`+2 cycles.
- Reset values: `DMEM_RDATA` = 0, `HCU_MEM_BUSY` = 0, `DMEM_DONE` = 0, `DMEM_ERR` = 0, state = `IDLE`, counter = 0.
- Store then load to the same address: the load observes the stored data. No bypass is needed, because accesses are serialised.

## Structure
- Shared package (`core_dmem_pkg`) holds:
  - the state encoding (2-bit);
  - the `STRB` legal-pattern constants;
  - the counter width of 4.
- Sub-module `core_dmem_lane_extract`: combinational load alignment and extension (`STRB`, sign flags, raw word -> result).
- The RAM array is inferred inside the top module with per-byte write enables.

## Test plan
- **Word store/load, `WAIT_STATES`=2.** Store 0xDEADBEEF at 0x10, then load word 0x10. Required: BUSY high for exactly 3 cycles per access, `DMEM_DONE` pulse in cycle T+3, `DMEM_RDATA` = 0xDEADBEEF from T+4.
- **Byte lanes.** Store byte 0x80 at 0x13 with `STRB`=1000 over word 0x11223344. Required: word reads 0x80223344. Signed byte load at 0x13 returns 0xFFFFFF80; unsigned returns 0x00000080.
- **Halfword.** Store 0x8001 at 0x22, `STRB`=1100. Required: signed half load returns 0xFFFF8001, unsigned returns 0x00008001, and the lower half of the word is unchanged.
- **Illegal requests.** Word load at 0x06; store at byte address 4*`DEPTH_WORDS`; both pulses high together. Required: `DMEM_ERR` and `DMEM_DONE` pulse together, a load returns `DMEM_RDATA` = 0, and the RAM is unchanged on readback.
- **Requests while busy.** Issue a second request while BUSY is high. Required: it is ignored. With `WAIT_STATES`=0, BUSY is high for exactly 1 cycle.
- **Reset mid-operation.** Assert `RST` mid-`WAIT` during a store of 0xCAFEF00D to 0x40. Required: BUSY = 0 the next cycle, no `DMEM_DONE`, and a later load of 0x40 returns the old contents.
